// File: rtl/fp_add_sequencer.sv
// Multi-cycle floating-point adder sequencer: exponent compare/swap,
// serial alignment, add/subtract, serial normalization, start/busy/done.
module fp_add_sequencer #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    localparam int W     = 1 + EXP_W + MANT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_EXP   = 3'd1;
    localparam logic [2:0] S_ALIGN = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_NORM  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_TOP  = {{(EXP_W-1){1'b1}}, 1'b0};

    logic [2:0]        state;
    logic [W-1:0]      op_a;
    logic [W-1:0]      op_b;
    logic              sign_l;
    logic              sign_s;
    logic [EXP_W-1:0]  exp_r;
    logic [EXP_W-1:0]  diff;
    logic [MANT_W:0]   mant_l;
    logic [MANT_W:0]   mant_s;
    logic [MANT_W+1:0] sum;
    logic              special;
    logic [W-1:0]      spec_val;

    logic              sign_a;
    logic              sign_b;
    logic [EXP_W-1:0]  exp_a;
    logic [EXP_W-1:0]  exp_b;
    logic [MANT_W-1:0] man_a;
    logic [MANT_W-1:0] man_b;
    logic              a_zero;
    logic              b_zero;
    logic              a_big;
    logic [MANT_W+1:0] add_sum;
    logic              accept;

    assign sign_a = op_a[W-1];
    assign sign_b = op_b[W-1];
    assign exp_a  = op_a[W-2 -: EXP_W];
    assign exp_b  = op_b[W-2 -: EXP_W];
    assign man_a  = op_a[MANT_W-1:0];
    assign man_b  = op_b[MANT_W-1:0];
    assign a_zero = (exp_a == '0);
    assign b_zero = (exp_b == '0);

    // Magnitude order is {exp, mant} as one unsigned number; ties keep A.
    assign a_big  = (op_a[W-2:0] >= op_b[W-2:0]);

    assign add_sum = (sign_l == sign_s)
                   ? {1'b0, mant_l} + {1'b0, mant_s}
                   : {1'b0, mant_l} - {1'b0, mant_s};

    // busy stays high through the done pulse, so that cycle never accepts.
    assign accept = start && !busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            op_a     <= '0;
            op_b     <= '0;
            sign_l   <= 1'b0;
            sign_s   <= 1'b0;
            exp_r    <= '0;
            diff     <= '0;
            mant_l   <= '0;
            mant_s   <= '0;
            sum      <= '0;
            special  <= 1'b0;
            spec_val <= '0;
        end else begin
            done <= 1'b0;
            if (done) begin
                busy <= 1'b0;
            end
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_a    <= a;
                        op_b    <= b;
                        special <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_EXP;
                    end
                end
                S_EXP: begin
                    if (a_zero) begin
                        special  <= 1'b1;
                        spec_val <= op_b;
                        state    <= S_DONE;
                    end else if (b_zero) begin
                        special  <= 1'b1;
                        spec_val <= op_a;
                        state    <= S_DONE;
                    end else begin
                        sign_l <= a_big ? sign_a : sign_b;
                        sign_s <= a_big ? sign_b : sign_a;
                        exp_r  <= a_big ? exp_a : exp_b;
                        diff   <= a_big ? exp_a - exp_b : exp_b - exp_a;
                        mant_l <= {1'b1, a_big ? man_a : man_b};
                        mant_s <= {1'b1, a_big ? man_b : man_a};
                        sum    <= '0;
                        state  <= (exp_a != exp_b) ? S_ALIGN : S_ADD;
                    end
                end
                S_ALIGN: begin
                    mant_s <= mant_s >> 1;
                    diff   <= diff - EXP_ONE;
                    if (diff == EXP_ONE || mant_s[MANT_W:1] == '0) begin
                        state <= S_ADD;
                    end
                end
                S_ADD: begin
                    if (add_sum == '0) begin
                        special  <= 1'b1;
                        spec_val <= '0;
                        state    <= S_DONE;
                    end else begin
                        sum   <= add_sum;
                        state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (sum[MANT_W+1]) begin
                        sum   <= sum >> 1;
                        exp_r <= exp_r + EXP_ONE;
                        if (exp_r == EXP_TOP) begin
                            special  <= 1'b1;
                            spec_val <= {sign_l, EXP_ONES, {MANT_W{1'b0}}};
                            state    <= S_DONE;
                        end
                    end else if (!sum[MANT_W]) begin
                        if (exp_r <= EXP_ONE) begin
                            special  <= 1'b1;
                            spec_val <= '0;
                            state    <= S_DONE;
                        end else begin
                            sum   <= sum << 1;
                            exp_r <= exp_r - EXP_ONE;
                        end
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    result <= special ? spec_val
                                      : {sign_l, exp_r, sum[MANT_W-1:0]};
                    done   <= 1'b1;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
